// File: rtl/alarm_ring_scheduler.sv
// rtl/alarm_ring_scheduler.sv - two-alarm ring/snooze/timeout sequencer
// Arbitrates alarm match edges, then runs ring, snooze and unattended-timeout sequencing.
module alarm_ring_scheduler #(
  parameter int SNOOZE_MIN       = 9,
  parameter int RING_TIMEOUT_MIN = 5,
  parameter int MAX_SNOOZE       = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       min_tick,
  input  logic       beat_tick,
  input  logic [1:0] match,
  input  logic       snooze,
  input  logic       dismiss,
  output logic       ringing,
  output logic       buzzer,
  output logic [1:0] active_id,
  output logic       snoozing,
  output logic [3:0] snooze_left,
  output logic [2:0] snooze_cnt,
  output logic [1:0] missed
);

  localparam logic [3:0] SNOOZE_LEN  = 4'(SNOOZE_MIN);
  localparam logic [3:0] TIMEOUT_LEN = 4'(RING_TIMEOUT_MIN);
  localparam logic [2:0] SNOOZE_MAX  = 3'(MAX_SNOOZE);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RING   = 2'd1,
    S_SNOOZE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] match_q;
  logic [1:0] pend_q, pend_d;
  logic [1:0] active_id_q, active_id_d;
  logic [1:0] missed_q, missed_d;
  logic [3:0] ring_cnt_q, ring_cnt_d;
  logic [3:0] snooze_left_q, snooze_left_d;
  logic [2:0] snooze_cnt_q, snooze_cnt_d;
  logic       buzzer_q, buzzer_d;
  logic       ringing_q, ringing_d;
  logic       snoozing_q, snoozing_d;
  logic [1:0] rise;
  logic [3:0] ring_cnt_inc;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      match_q       <= 2'b00;
      pend_q        <= 2'b00;
      active_id_q   <= 2'b00;
      missed_q      <= 2'b00;
      ring_cnt_q    <= 4'd0;
      snooze_left_q <= 4'd0;
      snooze_cnt_q  <= 3'd0;
      buzzer_q      <= 1'b0;
      ringing_q     <= 1'b0;
      snoozing_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      match_q       <= match;
      pend_q        <= pend_d;
      active_id_q   <= active_id_d;
      missed_q      <= missed_d;
      ring_cnt_q    <= ring_cnt_d;
      snooze_left_q <= snooze_left_d;
      snooze_cnt_q  <= snooze_cnt_d;
      buzzer_q      <= buzzer_d;
      ringing_q     <= ringing_d;
      snoozing_q    <= snoozing_d;
    end
  end

  always_comb begin
    rise          = match & ~match_q;
    ring_cnt_inc  = ring_cnt_q + 4'd1;
    state_d       = state_q;
    active_id_d   = active_id_q;
    missed_d      = missed_q;
    ring_cnt_d    = ring_cnt_q;
    snooze_left_d = snooze_left_q;
    snooze_cnt_d  = snooze_cnt_q;
    buzzer_d      = 1'b0;
    // A new edge from the alarm currently being served is dropped, not queued.
    pend_d        = pend_q | (rise & ~active_id_q);

    case (state_q)
      S_IDLE: begin
        if (dismiss) missed_d = 2'b00;
        if (pend_q != 2'b00) begin
          state_d      = S_RING;
          active_id_d  = pend_q[0] ? 2'b01 : 2'b10;
          pend_d       = pend_d & ~active_id_d;
          ring_cnt_d   = 4'd0;
          snooze_cnt_d = 3'd0;
          buzzer_d     = 1'b1;
        end
      end
      S_RING: begin
        buzzer_d = beat_tick ? ~buzzer_q : buzzer_q;
        if (min_tick) ring_cnt_d = ring_cnt_inc;
        if (dismiss) begin
          state_d     = S_IDLE;
          active_id_d = 2'b00;
          buzzer_d    = 1'b0;
        end else if (snooze && (snooze_cnt_q < SNOOZE_MAX)) begin
          state_d       = S_SNOOZE;
          snooze_left_d = SNOOZE_LEN;
          snooze_cnt_d  = snooze_cnt_q + 3'd1;
          buzzer_d      = 1'b0;
        end else if (min_tick && (ring_cnt_inc == TIMEOUT_LEN)) begin
          state_d     = S_IDLE;
          missed_d    = missed_q | active_id_q;
          active_id_d = 2'b00;
          buzzer_d    = 1'b0;
        end
      end
      S_SNOOZE: begin
        if (dismiss) begin
          state_d       = S_IDLE;
          active_id_d   = 2'b00;
          snooze_left_d = 4'd0;
        end else if (min_tick) begin
          if (snooze_left_q == 4'd1) begin
            state_d       = S_RING;
            snooze_left_d = 4'd0;
            ring_cnt_d    = 4'd0;
            buzzer_d      = 1'b1;
          end else begin
            snooze_left_d = snooze_left_q - 4'd1;
          end
        end
      end
      default: begin
        state_d     = S_IDLE;
        active_id_d = 2'b00;
      end
    endcase

    ringing_d  = (state_d == S_RING);
    snoozing_d = (state_d == S_SNOOZE);
  end

  assign ringing     = ringing_q;
  assign buzzer      = buzzer_q;
  assign active_id   = active_id_q;
  assign snoozing    = snoozing_q;
  assign snooze_left = snooze_left_q;
  assign snooze_cnt  = snooze_cnt_q;
  assign missed      = missed_q;

endmodule

// File: tb/tb_alarm_ring_scheduler.sv
// tb/tb_alarm_ring_scheduler.sv - bench for alarm_ring_scheduler
// Each step drives one cycle of inputs and queues the outputs expected after that clock edge.
module tb_alarm_ring_scheduler;

  typedef struct {
    logic       rst;
    logic       mt;
    logic       bt;
    logic [1:0] m;
    logic       sn;
    logic       dm;
    logic       ring;
    logic       buz;
    logic [1:0] aid;
    logic       snz;
    logic [3:0] sl;
    logic [2:0] sc;
    logic [1:0] mis;
  } vec_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       min_tick = 1'b0;
  logic       beat_tick = 1'b0;
  logic [1:0] match = 2'b00;
  logic       snooze = 1'b0;
  logic       dismiss = 1'b0;
  logic       ringing;
  logic       buzzer;
  logic [1:0] active_id;
  logic       snoozing;
  logic [3:0] snooze_left;
  logic [2:0] snooze_cnt;
  logic [1:0] missed;

  int   n_pass = 0;
  int   n_total = 0;
  int   step_no = 0;
  vec_t exp_q[$];
  vec_t tbl[$];

  alarm_ring_scheduler dut (
    .clock       (clock),
    .reset       (reset),
    .min_tick    (min_tick),
    .beat_tick   (beat_tick),
    .match       (match),
    .snooze      (snooze),
    .dismiss     (dismiss),
    .ringing     (ringing),
    .buzzer      (buzzer),
    .active_id   (active_id),
    .snoozing    (snoozing),
    .snooze_left (snooze_left),
    .snooze_cnt  (snooze_cnt),
    .missed      (missed)
  );

  always #5 clock = ~clock;

  function automatic vec_t v(input logic rst, input logic mt, input logic bt,
                             input logic [1:0] m, input logic sn, input logic dm,
                             input logic ring, input logic buz, input logic [1:0] aid,
                             input logic snz, input logic [3:0] sl, input logic [2:0] sc,
                             input logic [1:0] mis);
    vec_t r;
    r.rst = rst; r.mt = mt; r.bt = bt; r.m = m; r.sn = sn; r.dm = dm;
    r.ring = ring; r.buz = buz; r.aid = aid; r.snz = snz; r.sl = sl; r.sc = sc; r.mis = mis;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    n_total++;
    if (act == expv) n_pass++;
    else $display("FAIL %s at step %0d: got %0d expected %0d", name, step_no, act, expv);
  endtask

  task automatic compare_out();
    vec_t e;
    e = exp_q.pop_front();
    chk("ringing", int'(ringing), int'(e.ring));
    chk("buzzer", int'(buzzer), int'(e.buz));
    chk("active_id", int'(active_id), int'(e.aid));
    chk("snoozing", int'(snoozing), int'(e.snz));
    chk("snooze_left", int'(snooze_left), int'(e.sl));
    chk("missed", int'(missed), int'(e.mis));
    if (e.aid != 2'b00 || e.rst) chk("snooze_cnt", int'(snooze_cnt), int'(e.sc));
  endtask

  task automatic step(input vec_t s);
    @(negedge clock);
    reset = s.rst; min_tick = s.mt; beat_tick = s.bt;
    match = s.m; snooze = s.sn; dismiss = s.dm;
    exp_q.push_back(s);
    @(posedge clock);
    #1;
    step_no++;
    compare_out();
  endtask

  initial begin
    // rst mt bt m sn dm | ring buz aid snz sl sc mis
    tbl.push_back(v(1,0,0,2'b00,0,0, 0,0,2'b00,0,4'd0,3'd0,2'b00));
    tbl.push_back(v(1,0,0,2'b00,0,0, 0,0,2'b00,0,4'd0,3'd0,2'b00));
    tbl.push_back(v(0,0,0,2'b01,0,0, 0,0,2'b00,0,4'd0,3'd0,2'b00));
    tbl.push_back(v(0,0,0,2'b01,0,0, 1,1,2'b01,0,4'd0,3'd0,2'b00));
    tbl.push_back(v(0,0,1,2'b01,0,0, 1,0,2'b01,0,4'd0,3'd0,2'b00));
    tbl.push_back(v(0,0,1,2'b01,0,0, 1,1,2'b01,0,4'd0,3'd0,2'b00));
    tbl.push_back(v(0,1,0,2'b01,0,0, 1,1,2'b01,0,4'd0,3'd0,2'b00));
    tbl.push_back(v(0,0,0,2'b00,0,0, 1,1,2'b01,0,4'd0,3'd0,2'b00));
    tbl.push_back(v(0,0,0,2'b01,0,0, 1,1,2'b01,0,4'd0,3'd0,2'b00));
    tbl.push_back(v(0,0,0,2'b01,0,1, 0,0,2'b00,0,4'd0,3'd0,2'b00));
    tbl.push_back(v(0,0,0,2'b01,0,0, 0,0,2'b00,0,4'd0,3'd0,2'b00));
    tbl.push_back(v(0,0,0,2'b00,0,0, 0,0,2'b00,0,4'd0,3'd0,2'b00));
    // both alarms rise together: alarm1 first, one idle cycle, then alarm2
    tbl.push_back(v(0,0,0,2'b11,0,0, 0,0,2'b00,0,4'd0,3'd0,2'b00));
    tbl.push_back(v(0,0,0,2'b11,0,0, 1,1,2'b01,0,4'd0,3'd0,2'b00));
    tbl.push_back(v(0,0,0,2'b00,0,0, 1,1,2'b01,0,4'd0,3'd0,2'b00));
    tbl.push_back(v(0,0,0,2'b00,0,1, 0,0,2'b00,0,4'd0,3'd0,2'b00));
    tbl.push_back(v(0,0,0,2'b00,0,0, 1,1,2'b10,0,4'd0,3'd0,2'b00));
    tbl.push_back(v(0,0,1,2'b00,0,1, 0,0,2'b00,0,4'd0,3'd0,2'b00));
    tbl.push_back(v(0,0,0,2'b00,0,0, 0,0,2'b00,0,4'd0,3'd0,2'b00));
    // unattended timeout on alarm1, then alarm2, then dismiss in idle clears missed
    tbl.push_back(v(0,0,0,2'b01,0,0, 0,0,2'b00,0,4'd0,3'd0,2'b00));
    tbl.push_back(v(0,0,0,2'b01,0,0, 1,1,2'b01,0,4'd0,3'd0,2'b00));
    tbl.push_back(v(0,1,0,2'b00,0,0, 1,1,2'b01,0,4'd0,3'd0,2'b00));
    tbl.push_back(v(0,1,0,2'b00,0,0, 1,1,2'b01,0,4'd0,3'd0,2'b00));
    tbl.push_back(v(0,0,0,2'b00,0,0, 1,1,2'b01,0,4'd0,3'd0,2'b00));
    tbl.push_back(v(0,1,0,2'b00,0,0, 1,1,2'b01,0,4'd0,3'd0,2'b00));
    tbl.push_back(v(0,1,0,2'b00,0,0, 1,1,2'b01,0,4'd0,3'd0,2'b00));
    tbl.push_back(v(0,1,0,2'b00,0,0, 0,0,2'b00,0,4'd0,3'd0,2'b01));
    tbl.push_back(v(0,0,0,2'b00,0,0, 0,0,2'b00,0,4'd0,3'd0,2'b01));
    tbl.push_back(v(0,0,0,2'b10,0,0, 0,0,2'b00,0,4'd0,3'd0,2'b01));
    tbl.push_back(v(0,0,0,2'b10,0,0, 1,1,2'b10,0,4'd0,3'd0,2'b01));
    tbl.push_back(v(0,1,0,2'b00,0,0, 1,1,2'b10,0,4'd0,3'd0,2'b01));
    tbl.push_back(v(0,1,0,2'b00,0,0, 1,1,2'b10,0,4'd0,3'd0,2'b01));
    tbl.push_back(v(0,1,0,2'b00,0,0, 1,1,2'b10,0,4'd0,3'd0,2'b01));
    tbl.push_back(v(0,1,0,2'b00,0,0, 1,1,2'b10,0,4'd0,3'd0,2'b01));
    tbl.push_back(v(0,1,0,2'b00,0,0, 0,0,2'b00,0,4'd0,3'd0,2'b11));
    tbl.push_back(v(0,0,0,2'b00,0,1, 0,0,2'b00,0,4'd0,3'd0,2'b00));
    // snooze+dismiss together, then snooze coinciding with the would-be timeout tick
    tbl.push_back(v(0,0,0,2'b01,0,0, 0,0,2'b00,0,4'd0,3'd0,2'b00));
    tbl.push_back(v(0,0,0,2'b01,0,0, 1,1,2'b01,0,4'd0,3'd0,2'b00));
    tbl.push_back(v(0,0,0,2'b00,1,1, 0,0,2'b00,0,4'd0,3'd0,2'b00));
    tbl.push_back(v(0,0,0,2'b00,0,0, 0,0,2'b00,0,4'd0,3'd0,2'b00));
    tbl.push_back(v(0,0,0,2'b01,0,0, 0,0,2'b00,0,4'd0,3'd0,2'b00));
    tbl.push_back(v(0,0,0,2'b01,0,0, 1,1,2'b01,0,4'd0,3'd0,2'b00));
    tbl.push_back(v(0,1,0,2'b00,0,0, 1,1,2'b01,0,4'd0,3'd0,2'b00));
    tbl.push_back(v(0,1,0,2'b00,0,0, 1,1,2'b01,0,4'd0,3'd0,2'b00));
    tbl.push_back(v(0,1,0,2'b00,0,0, 1,1,2'b01,0,4'd0,3'd0,2'b00));
    tbl.push_back(v(0,1,0,2'b00,0,0, 1,1,2'b01,0,4'd0,3'd0,2'b00));
    tbl.push_back(v(0,1,0,2'b00,1,0, 0,0,2'b01,1,4'd9,3'd1,2'b00));
    tbl.push_back(v(0,0,0,2'b00,0,1, 0,0,2'b00,0,4'd0,3'd0,2'b00));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // level held for a long time yields a single event
    step(v(0,0,0,2'b01,0,0, 0,0,2'b00,0,4'd0,3'd0,2'b00));
    for (int i = 0; i < 100; i++)
      step(v(0,0,0,2'b01,0,0, 1,1,2'b01,0,4'd0,3'd0,2'b00));
    step(v(0,0,0,2'b01,0,1, 0,0,2'b00,0,4'd0,3'd0,2'b00));
    for (int i = 0; i < 10; i++)
      step(v(0,0,0,2'b01,0,0, 0,0,2'b00,0,4'd0,3'd0,2'b00));
    step(v(0,0,0,2'b00,0,0, 0,0,2'b00,0,4'd0,3'd0,2'b00));

    // three full snooze cycles, fourth snooze ignored
    step(v(0,0,0,2'b01,0,0, 0,0,2'b00,0,4'd0,3'd0,2'b00));
    step(v(0,0,0,2'b00,0,0, 1,1,2'b01,0,4'd0,3'd0,2'b00));
    for (int s = 1; s <= 3; s++) begin
      step(v(0,0,0,2'b00,1,0, 0,0,2'b01,1,4'd9,3'(s),2'b00));
      for (int k = 1; k <= 9; k++) begin
        if (k < 9)
          step(v(0,1,(k == 5),2'b00,(k == 3),0, 0,0,2'b01,1,4'(9 - k),3'(s),2'b00));
        else
          step(v(0,1,0,2'b00,0,0, 1,1,2'b01,0,4'd0,3'(s),2'b00));
        if (k == 4)
          step(v(0,0,0,2'b00,0,0, 0,0,2'b01,1,4'd5,3'(s),2'b00));
      end
    end
    step(v(0,0,0,2'b00,1,0, 1,1,2'b01,0,4'd0,3'd3,2'b00));
    step(v(0,0,0,2'b00,0,1, 0,0,2'b00,0,4'd0,3'd3,2'b00));

    // reset while snoozing with alarm2 pending discards everything
    step(v(0,0,0,2'b01,0,0, 0,0,2'b00,0,4'd0,3'd0,2'b00));
    step(v(0,0,0,2'b00,0,0, 1,1,2'b01,0,4'd0,3'd0,2'b00));
    step(v(0,0,0,2'b00,1,0, 0,0,2'b01,1,4'd9,3'd1,2'b00));
    step(v(0,0,0,2'b10,0,0, 0,0,2'b01,1,4'd9,3'd1,2'b00));
    step(v(0,0,0,2'b10,0,0, 0,0,2'b01,1,4'd9,3'd1,2'b00));
    step(v(1,0,0,2'b00,0,0, 0,0,2'b00,0,4'd0,3'd0,2'b00));
    for (int i = 0; i < 5; i++)
      step(v(0,(i == 2),0,2'b00,0,0, 0,0,2'b00,0,4'd0,3'd0,2'b00));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
